arg_pack: RTL and testbench
===========================

Name: arg_pack

Overview:
- Inverse of the sync PE's task-to-argument path: gathers consecutive 64-bit argument beats from an AXI-Stream and packs each pair into one 128-bit task word.
- Beat 0 of a pair goes to bits [63:0] and beat 1 to bits [127:64], so the sync PE's upper-half extraction returns the second argument.
- Sits between argument producers and the task queue input of a PE/scheduler port.
- Registered output, full input throughput, per-block emitted-task counter for debug.

Parameters:
- ARG_WIDTH, 64, width of one argument beat.
- TASK_WIDTH, 128, width of an emitted task; must equal 2*ARG_WIDTH.
- CNT_WIDTH, 32, width of the emitted-task counter.

Ports:
- ap_clk  input  1  clock; all logic on rising edge.
- ap_rst  input  1  synchronous, active-high reset.
- argIn_TDATA  input  ARG_WIDTH  argument beat.
- argIn_TVALID  input  1  beat valid.
- argIn_TREADY  output  1  block accepts beat.
- taskOut_TDATA  output  TASK_WIDTH  packed task.
- taskOut_TVALID  output  1  task valid.
- taskOut_TREADY  input  1  downstream accepts task.
- taskCount  output  CNT_WIDTH  number of taskOut handshakes since reset.

Behaviour:
- Reset (ap_rst=1 at a clock edge) clears the following:
  - state to LO and the held lower half to 0.
  - taskOut_TVALID to 0, taskOut_TDATA to 0 and taskCount to 0.
- Reset has priority over every other event. A lower half held mid-pair is discarded and is never emitted.
- In_hs = argIn_TVALID & argIn_TREADY. Out_hs = taskOut_TVALID & taskOut_TREADY.
- out_free = !taskOut_TVALID | taskOut_TREADY. This is combinational from taskOut_TREADY, which is allowed.
- State LO (no lower half held):
  - argIn_TREADY = 1.
  - on in_hs: latch TDATA into lo_reg and move to HI.
- State HI (lower half held):
  - argIn_TREADY = out_free.
  - on in_hs: taskOut_TDATA <= {argIn_TDATA, lo_reg}, taskOut_TVALID <= 1, state returns to LO.
- Output register:
  - On out_hs without a new load, taskOut_TVALID <= 0.
  - Load and out_hs in the same cycle: the new task replaces the old one and TVALID stays 1. There is no bubble.
  - taskOut_TDATA is stable while TVALID=1 and TREADY=0.
- Latency: the task is visible on the cycle after the second beat's handshake.
- Throughput: one argument per cycle sustained, i.e. one task per 2 cycles, when TREADY stays high.
- Backpressure:
  - In HI with the output full and TREADY=0, argIn_TREADY=0 and lo_reg is held.
  - In LO, a beat is accepted even while the output is stalled. This gives at most 1 task plus 1 half buffered.
- taskCount increments by 1 on each out_hs and wraps modulo 2^CNT_WIDTH (all-ones goes to 0).
- Input TVALID without handshake: no state change. The block does not require TDATA to be held stable while TREADY=0; it samples only on in_hs.

Optional Feature:
- Macro ARG_PACK_TLAST_EN.
- Defined: adds ports argIn_TLAST (input, 1) and taskOut_TLAST (output, 1, reset 0).
  - TLAST=1 on a beat accepted in LO emits a half task {0, argIn_TDATA} with taskOut_TLAST=1 and stays in LO.
  - For that reason, in LO argIn_TREADY = out_free when argIn_TLAST=1, else 1.
  - TLAST on a beat accepted in HI sets taskOut_TLAST=1 on the completed pair.
  - taskOut_TLAST is held with TDATA.
- Undefined: no TLAST ports; beats always pair strictly.

Test Plan:
- Reset, then beats 0x11 and 0x22 with TREADY=1 -> one cycle after beat 2: TDATA=0x22<<64|0x11, TVALID=1; next cycle TVALID=0, taskCount=1.
- 8 back-to-back beats 1..8, TREADY=1 -> argIn_TREADY constantly 1; tasks {2,1},{4,3},{6,5},{8,7} on alternate cycles; taskCount=4.
- TREADY=0, send beats A,B,C,D:
  - after task {B,A}, C is accepted and argIn_TREADY=0 while D is offered.
  - raise TREADY -> {B,A} taken, D accepted the same cycle, {D,C} follows with no bubble.
- Send one beat 0x55, assert ap_rst for 1 cycle, then send 0x66, 0x77 -> only task {0x77,0x66} emitted; taskCount=1.
- Force taskCount=2^32-1 (preload via 2^CNT_WIDTH-1 handshakes or CNT_WIDTH=4 with 15 tasks) -> next task wraps taskCount to 0.
- ARG_PACK_TLAST_EN: beat 0x9 with TLAST=1 in LO -> task {0,0x9} with TLAST=1. Then 0x1, then 0x2 with TLAST=1 -> task {0x2,0x1} with TLAST=1.

Source files
------------

// File: rtl/arg_pack.sv
// rtl/arg_pack.sv - packs pairs of ARG_WIDTH argument beats into one TASK_WIDTH task word; ARG_PACK_TLAST_EN adds TLAST framing
module arg_pack #(
  parameter int ARG_WIDTH  = 64,
  parameter int TASK_WIDTH = 128,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [ARG_WIDTH-1:0]  argIn_TDATA,
  input  logic                  argIn_TVALID,
  output logic                  argIn_TREADY,
`ifdef ARG_PACK_TLAST_EN
  input  logic                  argIn_TLAST,
  output logic                  taskOut_TLAST,
`endif
  output logic [TASK_WIDTH-1:0] taskOut_TDATA,
  output logic                  taskOut_TVALID,
  input  logic                  taskOut_TREADY,
  output logic [CNT_WIDTH-1:0]  taskCount
);

  localparam logic ST_LO = 1'b0;
  localparam logic ST_HI = 1'b1;

  logic                  state_q, state_d;
  logic [ARG_WIDTH-1:0]  lo_q, lo_d;
  logic [TASK_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  in_last;
  logic                  out_free;
  logic                  in_hs;
  logic                  out_hs;

`ifdef ARG_PACK_TLAST_EN
  logic last_q, last_d;
  assign in_last = argIn_TLAST;
`else
  assign in_last = 1'b0;
`endif

  assign out_free = !valid_q | taskOut_TREADY;

  // A beat in LO only needs the output register when it closes a frame on its own.
  always_comb begin
    argIn_TREADY = 1'b1;
    if (state_q == ST_HI || in_last) begin
      argIn_TREADY = out_free;
    end
  end

  assign in_hs  = argIn_TVALID & argIn_TREADY;
  assign out_hs = valid_q & taskOut_TREADY;

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    data_d  = data_q;
    valid_d = valid_q;
`ifdef ARG_PACK_TLAST_EN
    last_d  = last_q;
`endif
    count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, out_hs};
    if (out_hs) begin
      valid_d = 1'b0;
    end
    if (in_hs) begin
      if (state_q == ST_HI) begin
        data_d  = {argIn_TDATA, lo_q};
        valid_d = 1'b1;
        state_d = ST_LO;
`ifdef ARG_PACK_TLAST_EN
        last_d  = in_last;
`endif
      end else if (in_last) begin
        data_d  = {{ARG_WIDTH{1'b0}}, argIn_TDATA};
        valid_d = 1'b1;
`ifdef ARG_PACK_TLAST_EN
        last_d  = 1'b1;
`endif
      end else begin
        lo_d    = argIn_TDATA;
        state_d = ST_HI;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= ST_LO;
      lo_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
`ifdef ARG_PACK_TLAST_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
`ifdef ARG_PACK_TLAST_EN
      last_q  <= last_d;
`endif
    end
  end

  assign taskOut_TDATA  = data_q;
  assign taskOut_TVALID = valid_q;
  assign taskCount      = count_q;
`ifdef ARG_PACK_TLAST_EN
  assign taskOut_TLAST  = last_q;
`endif

endmodule

// File: tb/tb_arg_pack.sv
// tb/tb_arg_pack.sv - directed self-checking bench for arg_pack
module tb_arg_pack;

  localparam int AW = 64;
  localparam int TW = 128;
  localparam int CW = 4;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic [AW-1:0] argIn_TDATA = '0;
  logic          argIn_TVALID = 1'b0;
  logic          argIn_TREADY;
  logic [TW-1:0] taskOut_TDATA;
  logic          taskOut_TVALID;
  logic          taskOut_TREADY = 1'b0;
  logic [CW-1:0] taskCount;
`ifdef ARG_PACK_TLAST_EN
  logic          argIn_TLAST = 1'b0;
  logic          taskOut_TLAST;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ap_clk = ~ap_clk;

  arg_pack #(.ARG_WIDTH(AW), .TASK_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .argIn_TDATA   (argIn_TDATA),
    .argIn_TVALID  (argIn_TVALID),
    .argIn_TREADY  (argIn_TREADY),
`ifdef ARG_PACK_TLAST_EN
    .argIn_TLAST   (argIn_TLAST),
    .taskOut_TLAST (taskOut_TLAST),
`endif
    .taskOut_TDATA (taskOut_TDATA),
    .taskOut_TVALID(taskOut_TVALID),
    .taskOut_TREADY(taskOut_TREADY),
    .taskCount     (taskCount)
  );

  task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    argIn_TVALID = 1'b0;
    ap_rst = 1'b1;
    cyc();
    ap_rst = 1'b0;
  endtask

  function automatic logic [TW-1:0] pair(input logic [AW-1:0] hi, input logic [AW-1:0] lo);
    return {hi, lo};
  endfunction

  initial begin
    cyc();
    do_reset();
    chk("rst_valid", taskOut_TVALID, 0);
    chk("rst_data", taskOut_TDATA, 0);
    chk("rst_count", taskCount, 0);
    chk("rst_ready", argIn_TREADY, 1);

    // basic pair
    taskOut_TREADY = 1'b1;
    argIn_TVALID = 1'b1;
    argIn_TDATA = 64'h11;
    cyc();
    argIn_TDATA = 64'h22;
    cyc();
    argIn_TVALID = 1'b0;
    chk("t1_valid", taskOut_TVALID, 1);
    chk("t1_data", taskOut_TDATA, pair(64'h22, 64'h11));
    cyc();
    chk("t1_valid_drop", taskOut_TVALID, 0);
    chk("t1_count", taskCount, 1);

    // back-to-back streaming
    do_reset();
    taskOut_TREADY = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      argIn_TVALID = 1'b1;
      argIn_TDATA = AW'(i);
      #1;
      chk("t2_ready", argIn_TREADY, 1);
      cyc();
      if (i % 2 == 0) begin
        chk("t2_valid", taskOut_TVALID, 1);
        chk("t2_data", taskOut_TDATA, pair(AW'(i), AW'(i - 1)));
      end else if (i > 1) begin
        chk("t2_bubble", taskOut_TVALID, 0);
      end
    end
    argIn_TVALID = 1'b0;
    cyc();
    chk("t2_count", taskCount, 4);

    // backpressure
    do_reset();
    taskOut_TREADY = 1'b0;
    argIn_TVALID = 1'b1;
    argIn_TDATA = 64'hA;
    cyc();
    argIn_TDATA = 64'hB;
    cyc();
    argIn_TDATA = 64'hC;
    #1;
    chk("t3_c_ready", argIn_TREADY, 1);
    cyc();
    argIn_TDATA = 64'hD;
    #1;
    chk("t3_d_stall", argIn_TREADY, 0);
    chk("t3_ba", taskOut_TDATA, pair(64'hB, 64'hA));
    cyc();
    chk("t3_d_stall2", argIn_TREADY, 0);
    chk("t3_ba_hold", taskOut_TDATA, pair(64'hB, 64'hA));
    chk("t3_ba_valid", taskOut_TVALID, 1);
    taskOut_TREADY = 1'b1;
    #1;
    chk("t3_d_ready", argIn_TREADY, 1);
    cyc();
    argIn_TVALID = 1'b0;
    chk("t3_dc", taskOut_TDATA, pair(64'hD, 64'hC));
    chk("t3_dc_valid", taskOut_TVALID, 1);
    chk("t3_count1", taskCount, 1);
    cyc();
    chk("t3_count2", taskCount, 2);
    chk("t3_empty", taskOut_TVALID, 0);

    // reset discards a held half
    do_reset();
    taskOut_TREADY = 1'b1;
    argIn_TVALID = 1'b1;
    argIn_TDATA = 64'h55;
    cyc();
    do_reset();
    argIn_TVALID = 1'b1;
    argIn_TDATA = 64'h66;
    cyc();
    chk("t4_no_task", taskOut_TVALID, 0);
    argIn_TDATA = 64'h77;
    cyc();
    argIn_TVALID = 1'b0;
    chk("t4_data", taskOut_TDATA, pair(64'h77, 64'h66));
    chk("t4_valid", taskOut_TVALID, 1);
    cyc();
    chk("t4_count", taskCount, 1);

    // counter wrap
    do_reset();
    taskOut_TREADY = 1'b1;
    argIn_TVALID = 1'b1;
    for (int i = 0; i < 30; i++) begin
      argIn_TDATA = AW'(i);
      cyc();
    end
    argIn_TVALID = 1'b0;
    cyc();
    chk("t5_count15", taskCount, 15);
    argIn_TVALID = 1'b1;
    cyc();
    cyc();
    argIn_TVALID = 1'b0;
    cyc();
    chk("t5_wrap", taskCount, 0);

`ifdef ARG_PACK_TLAST_EN
    do_reset();
    taskOut_TREADY = 1'b1;
    argIn_TVALID = 1'b1;
    argIn_TLAST = 1'b1;
    argIn_TDATA = 64'h9;
    cyc();
    chk("t6_half", taskOut_TDATA, pair(64'h0, 64'h9));
    chk("t6_half_valid", taskOut_TVALID, 1);
    chk("t6_half_last", taskOut_TLAST, 1);
    argIn_TLAST = 1'b0;
    argIn_TDATA = 64'h1;
    cyc();
    chk("t6_mid_valid", taskOut_TVALID, 0);
    argIn_TLAST = 1'b1;
    argIn_TDATA = 64'h2;
    cyc();
    argIn_TVALID = 1'b0;
    argIn_TLAST = 1'b0;
    chk("t6_pair", taskOut_TDATA, pair(64'h2, 64'h1));
    chk("t6_pair_last", taskOut_TLAST, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
